// File: rtl/program_loader.sv
// program_loader: receives a framed program image byte by byte over a
// valid/ready handshake, writes the data bytes into the register file and
// verifies the XOR checksum before handing memory to the controller.
module program_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write,
    output logic                  busy,
    output logic                  run,
    output logic                  error
);

    // Counter is one bit wider than the address so a full-depth count fits.
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    // Program length lives in the low five bits of the header byte.
    localparam int unsigned LEN_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   xor_acc;
    logic [CNT_W-1:0]        addr_cnt;
    logic [CNT_W-1:0]        n_len;

    logic [LEN_W-1:0]        hdr_len;
    logic                    hdr_bad;
    logic [CNT_W-1:0]        addr_next;
    logic                    xfer;

    // Header decode, counter increment and handshake qualifier.
    assign hdr_len   = byte_in[LEN_W-1:0];
    assign hdr_bad   = (hdr_len == LEN_W'(0)) || (32'(hdr_len) > DEPTH);
    assign addr_next = addr_cnt + CNT_W'(1);
    assign xfer      = byte_valid && byte_ready;

    // Load sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            xor_acc     <= '0;
            addr_cnt    <= '0;
            n_len       <= '0;
            byte_ready  <= 1'b0;
            mem_data    <= '0;
            mem_address <= '0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            run         <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_HEADER;
                        addr_cnt   <= '0;
                        xor_acc    <= '0;
                        run        <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        xor_acc <= byte_in;
                        n_len   <= CNT_W'(hdr_len);
                        if (hdr_bad) begin
                            state      <= S_ERROR;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // Write cycle: fold the byte into the checksum and advance.
                    if (mem_write) begin
                        xor_acc    <= xor_acc ^ mem_data;
                        addr_cnt   <= addr_next;
                        byte_ready <= 1'b1;
                        if (addr_next == n_len) begin
                            state <= S_CHECK;
                        end
                    end else if (xfer) begin
                        mem_data    <= byte_in;
                        mem_address <= addr_cnt[ADDR_WIDTH-1:0];
                        mem_write   <= 1'b1;
                        byte_ready  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        if (byte_in == xor_acc) begin
                            state <= S_DONE;
                            run   <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus randomized frames checked
// against a frame-level reference (expected writes, checksum verdict, image).
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] mem_data;
    logic [3:0] mem_address;
    logic       mem_write;
    logic       busy;
    logic       run;
    logic       error;

    program_loader #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .DEPTH     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_data   (mem_data),
        .mem_address(mem_address),
        .mem_write  (mem_write),
        .busy       (busy),
        .run        (run),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Register file stand-in: captures whatever the loader writes.
    logic [7:0] shadow [16];
    int         wr_count = 0;
    always @(posedge clk) begin
        if (mem_write) begin
            shadow[mem_address] <= mem_data;
            wr_count            <= wr_count + 1;
        end
    end

    logic [7:0] ref_mem [16];
    bit         ref_written [16];
    logic [7:0] fd [16];
    int         checks = 0;
    int         fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {byte_ready, busy, run, error, mem_write}
    task automatic check_status(input string tag, input logic [4:0] exp);
        check(tag, 32'({byte_ready, busy, run, error, mem_write}), 32'(exp));
    endtask

    // Present a byte, wait (bounded) for ready, let it transfer; returns at the
    // negedge after the transfer edge with the number of cycles waited.
    task automatic send_byte(input logic [7:0] b, output int waited);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        waited = n;
    endtask

    task automatic run_frame(input logic [7:0] hdr, input int gaps, input bit hold,
                             input logic [8:0] cs_force, input int start_mid_at,
                             input int reset_at);
        int         n;
        int         w;
        int         wc0;
        logic [7:0] xr;
        logic [7:0] cs;
        bit         exp_run;
        n   = int'(hdr[4:0]);
        xr  = hdr;
        wc0 = wr_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_status("after_start", 5'b11000);
        send_byte(hdr, w);
        if (!hold) byte_valid = 1'b0;
        if (n == 0 || n > 16) begin
            byte_valid = 1'b0;
            check_status("bad_header", 5'b00010);
            @(negedge clk);
            check("bad_header_writes", 32'(wr_count), 32'(wc0));
            return;
        end
        check_status("after_header", 5'b11000);
        for (int i = 0; i < n; i++) begin
            if (gaps > 0) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(gaps, 0)) @(negedge clk);
            end
            send_byte(fd[i], w);
            if (hold) check("ready_alternation", 32'(w), (i == 0) ? 32'd0 : 32'd1);
            ref_mem[i]     = fd[i];
            ref_written[i] = 1'b1;
            xr             = xr ^ fd[i];
            check_status("write_pulse", 5'b01001);
            check("write_addr", 32'(mem_address), 32'(i));
            check("write_data", 32'(mem_data), 32'(fd[i]));
            if (!hold) byte_valid = 1'b0;
            if (i == reset_at) begin
                byte_valid = 1'b0;
                reset      = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("reset_mid_load", 32'({byte_ready, busy, run, error, mem_write,
                                             mem_address, mem_data}), 32'd0);
                return;
            end
            if (i == start_mid_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_status("start_ignored", 5'b11000);
            end
        end
        cs      = cs_force[8] ? cs_force[7:0] : xr;
        exp_run = (cs == xr);
        send_byte(cs, w);
        if (hold) check("ready_alternation", 32'(w), 32'd1);
        byte_valid = 1'b0;
        check_status("verdict", {2'b00, exp_run, !exp_run, 1'b0});
        check("write_count", 32'(wr_count - wc0), 32'(n));
        for (int a = 0; a < 16; a++) begin
            if (ref_written[a]) check("mem_image", 32'(shadow[a]), 32'(ref_mem[a]));
        end
    endtask

    initial begin
        int         n;
        int         g;
        logic [7:0] hdr;
        logic [7:0] xr;
        logic [8:0] csf;
        for (int a = 0; a < 16; a++) ref_written[a] = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_state", 32'({byte_ready, busy, run, error, mem_write,
                                  mem_address, mem_data}), 32'd0);

        // Basic frame; a valid byte alongside start in IDLE must not be consumed.
        fd[0] = 8'hA1; fd[1] = 8'hB2; fd[2] = 8'hC3;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        run_frame(8'h03, 0, 1'b0, 9'h000, -1, -1);

        // Same data with a wrong checksum.
        run_frame(8'h03, 0, 1'b0, 9'h100, -1, -1);

        // Illegal lengths.
        run_frame(8'h00, 0, 1'b0, 9'h000, -1, -1);
        run_frame(8'h11, 0, 1'b0, 9'h000, -1, -1);

        // Full-depth frame with byte_valid held high throughout.
        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        run_frame(8'h10, 0, 1'b1, 9'h000, -1, -1);

        // Reset after the second data byte, then a fresh two-byte load.
        fd[0] = 8'h5A; fd[1] = 8'hC6; fd[2] = 8'h77; fd[3] = 8'h18;
        run_frame(8'h04, 0, 1'b0, 9'h000, -1, 1);
        fd[0] = 8'h3C; fd[1] = 8'h81;
        run_frame(8'h02, 0, 1'b0, 9'h000, -1, -1);

        // Start pulsed mid-load is ignored.
        for (int i = 0; i < 5; i++) fd[i] = 8'($urandom);
        run_frame(8'h05, 0, 1'b0, 9'h000, 2, -1);

        // Randomized frames: lengths, gaps, handshake style, checksum corruption.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(9, 0) == 0)
                n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(31, 17));
            else
                n = int'($urandom_range(16, 1));
            hdr = {3'($urandom), 5'(n)};
            xr  = hdr;
            for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
            for (int i = 0; i < n && i < 16; i++) xr = xr ^ fd[i];
            if ($urandom_range(2, 0) == 0) csf = {1'b1, xr ^ 8'($urandom_range(255, 1))};
            else                           csf = 9'h000;
            g = int'($urandom_range(3, 0));
            run_frame(hdr, g, (g == 0) && ($urandom_range(1, 0) == 1), csf, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
